// File: rtl/ddr3_axi_bist.sv
// Write-then-read memory BIST for a DDR3 AXI4 slave: fills num_bursts INCR bursts
// with an address-derived pattern, reads them back and counts/locates mismatches.
module ddr3_axi_bist #(
    parameter int BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] num_bursts,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,

    output logic [31:0] axi4_awaddr,
    output logic [7:0]  axi4_awlen,
    output logic [1:0]  axi4_awburst,
    output logic        axi4_awvalid,
    input  logic        axi4_awready,

    output logic [31:0] axi4_wdata,
    output logic [3:0]  axi4_wstrb,
    output logic        axi4_wlast,
    output logic        axi4_wvalid,
    input  logic        axi4_wready,

    input  logic [1:0]  axi4_bresp,
    input  logic        axi4_bvalid,
    output logic        axi4_bready,

    output logic [31:0] axi4_araddr,
    output logic [7:0]  axi4_arlen,
    output logic [1:0]  axi4_arburst,
    output logic        axi4_arvalid,
    input  logic        axi4_arready,

    input  logic [31:0] axi4_rdata,
    input  logic [1:0]  axi4_rresp,
    input  logic        axi4_rlast,
    input  logic        axi4_rvalid,
    output logic        axi4_rready
);

    localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [31:0] STRIDE    = 32'(BURST_LEN * 4);
    localparam logic [31:0] PATTERN   = 32'hA5A5A5A5;

    typedef enum logic [2:0] {
        IDLE,
        WA,
        WD,
        WB,
        RA,
        RD,
        FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_busy;
    logic        r_done;
    logic [15:0] r_err_count;
    logic [31:0] r_first_err_addr;
    logic [31:0] r_base;
    logic [31:0] r_addr;
    logic [15:0] r_num_bursts;
    logic [15:0] r_burst_cnt;
    logic [7:0]  r_beat;

    logic [31:0] w_beat_addr;
    logic [31:0] w_expect;
    logic        w_last_beat;
    logic        w_last_burst;
    logic        w_b_err;
    logic        w_r_err;
    logic        w_err;
    logic [31:0] w_err_addr;

    // The pattern is a pure function of the beat address, so the read side
    // regenerates it instead of storing what was written.
    assign w_beat_addr  = r_addr + {22'd0, r_beat, 2'b00};
    assign w_expect     = w_beat_addr ^ PATTERN;
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_last_burst = (r_burst_cnt == r_num_bursts - 16'd1);

    assign w_b_err = (r_state == WB) && axi4_bvalid && (axi4_bresp != 2'b00);
    assign w_r_err = (r_state == RD) && axi4_rvalid &&
                     ((axi4_rdata != w_expect) || (axi4_rresp != 2'b00) ||
                      (axi4_rlast != w_last_beat));
    assign w_err      = w_b_err || w_r_err;
    assign w_err_addr = (r_state == WB) ? r_addr : w_beat_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: state and datapath registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of process evaluation order.
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        w_next       = r_state;
        axi4_awvalid = 1'b0;
        axi4_wvalid  = 1'b0;
        axi4_bready  = 1'b0;
        axi4_arvalid = 1'b0;
        axi4_rready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (num_bursts == 16'd0) ? FIN : WA;
                end
            end
            WA: begin
                axi4_awvalid = 1'b1;
                if (axi4_awready) w_next = WD;
            end
            WD: begin
                axi4_wvalid = 1'b1;
                if (axi4_wready && w_last_beat) w_next = WB;
            end
            WB: begin
                axi4_bready = 1'b1;
                if (axi4_bvalid) w_next = w_last_burst ? RA : WA;
            end
            RA: begin
                axi4_arvalid = 1'b1;
                if (axi4_arready) w_next = RD;
            end
            RD: begin
                axi4_rready = 1'b1;
                if (axi4_rvalid && w_last_beat) w_next = w_last_burst ? FIN : RA;
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= 32'd0;
            r_base           <= 32'd0;
            r_addr           <= 32'd0;
            r_num_bursts     <= 16'd0;
            r_burst_cnt      <= 16'd0;
            r_beat           <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_err_count      <= 16'd0;
                        r_first_err_addr <= 32'd0;
                        r_base           <= base_addr & ~32'h3;
                        r_addr           <= base_addr & ~32'h3;
                        r_num_bursts     <= num_bursts;
                        r_burst_cnt      <= 16'd0;
                        r_beat           <= 8'd0;
                    end
                end
                WD: begin
                    if (axi4_wready) r_beat <= w_last_beat ? 8'd0 : r_beat + 8'd1;
                end
                WB: begin
                    if (axi4_bvalid) begin
                        if (w_last_burst) begin
                            r_burst_cnt <= 16'd0;
                            r_addr      <= r_base;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 16'd1;
                            r_addr      <= r_addr + STRIDE;
                        end
                    end
                end
                RD: begin
                    if (axi4_rvalid) begin
                        // A missing rlast still closes the burst on the last beat.
                        if (w_last_beat) begin
                            r_beat      <= 8'd0;
                            r_burst_cnt <= r_burst_cnt + 16'd1;
                            r_addr      <= r_addr + STRIDE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                FIN: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase

            if (w_err) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                if (r_err_count == 16'd0)    r_first_err_addr <= w_err_addr;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_done && (r_err_count == 16'd0);
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

    assign axi4_awaddr  = (r_state == WA) ? r_addr    : 32'd0;
    assign axi4_awlen   = (r_state == WA) ? LAST_BEAT : 8'd0;
    assign axi4_awburst = (r_state == WA) ? 2'b01     : 2'b00;

    assign axi4_wdata = (r_state == WD) ? w_expect : 32'd0;
    assign axi4_wstrb = (r_state == WD) ? 4'hF     : 4'h0;
    assign axi4_wlast = (r_state == WD) && w_last_beat;

    assign axi4_araddr  = (r_state == RA) ? r_addr    : 32'd0;
    assign axi4_arlen   = (r_state == RA) ? LAST_BEAT : 8'd0;
    assign axi4_arburst = (r_state == RA) ? 2'b01     : 2'b00;

endmodule

// File: tb/tb_ddr3_axi_bist.sv
// Directed bench for ddr3_axi_bist (BURST_LEN=4) against a small AXI memory slave
// with optional random ready/valid stalls and a single-address read corruption.
module tb_ddr3_axi_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_bursts;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic [31:0] axi4_awaddr;
    logic [7:0]  axi4_awlen;
    logic [1:0]  axi4_awburst;
    logic        axi4_awvalid, axi4_awready;
    logic [31:0] axi4_wdata;
    logic [3:0]  axi4_wstrb;
    logic        axi4_wlast, axi4_wvalid, axi4_wready;
    logic [1:0]  axi4_bresp;
    logic        axi4_bvalid, axi4_bready;
    logic [31:0] axi4_araddr;
    logic [7:0]  axi4_arlen;
    logic [1:0]  axi4_arburst;
    logic        axi4_arvalid, axi4_arready;
    logic [31:0] axi4_rdata;
    logic [1:0]  axi4_rresp;
    logic        axi4_rlast, axi4_rvalid, axi4_rready;

    ddr3_axi_bist #(.BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .axi4_awaddr(axi4_awaddr), .axi4_awlen(axi4_awlen), .axi4_awburst(axi4_awburst),
        .axi4_awvalid(axi4_awvalid), .axi4_awready(axi4_awready),
        .axi4_wdata(axi4_wdata), .axi4_wstrb(axi4_wstrb), .axi4_wlast(axi4_wlast),
        .axi4_wvalid(axi4_wvalid), .axi4_wready(axi4_wready),
        .axi4_bresp(axi4_bresp), .axi4_bvalid(axi4_bvalid), .axi4_bready(axi4_bready),
        .axi4_araddr(axi4_araddr), .axi4_arlen(axi4_arlen), .axi4_arburst(axi4_arburst),
        .axi4_arvalid(axi4_arvalid), .axi4_arready(axi4_arready),
        .axi4_rdata(axi4_rdata), .axi4_rresp(axi4_rresp), .axi4_rlast(axi4_rlast),
        .axi4_rvalid(axi4_rvalid), .axi4_rready(axi4_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    logic [31:0] aw_log [$];
    logic [31:0] ar_log [$];
    logic [31:0] first_wdata;
    bit          first_w_seen;
    logic [7:0]  last_awlen, last_arlen;
    logic [1:0]  last_awburst, last_arburst;
    logic [3:0]  last_wstrb;
    logic [31:0] wptr, rptr;
    int          r_left;
    int          w_in_burst;
    bit          b_pend;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int          w_beats;
    int          wlast_viol;
    bit          stall_en;
    int          aw_wait, w_wait, ar_wait, r_wait;
    int          stall_viol, stall_cycles;
    bit          valid_seen;
    logic [31:0] flip_addr;
    bit          aw_hold, w_hold, ar_hold;
    logic [31:0] aw_prev, w_prev, ar_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Protocol monitor: samples handshakes on the active edge and keeps the memory model.
    always @(posedge clk) begin
        if (!rst_n) begin
            b_pend = 0; r_left = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        end else begin
            aw_hs = axi4_awvalid && axi4_awready;
            w_hs  = axi4_wvalid  && axi4_wready;
            b_hs  = axi4_bvalid  && axi4_bready;
            ar_hs = axi4_arvalid && axi4_arready;
            r_hs  = axi4_rvalid  && axi4_rready;
            if (aw_hold && !(axi4_awvalid && axi4_awaddr == aw_prev)) stall_viol++;
            if (w_hold  && !(axi4_wvalid  && axi4_wdata  == w_prev))  stall_viol++;
            if (ar_hold && !(axi4_arvalid && axi4_araddr == ar_prev)) stall_viol++;
            aw_hold = axi4_awvalid && !axi4_awready; aw_prev = axi4_awaddr;
            w_hold  = axi4_wvalid  && !axi4_wready;  w_prev  = axi4_wdata;
            ar_hold = axi4_arvalid && !axi4_arready; ar_prev = axi4_araddr;
            if (aw_hold || w_hold || ar_hold) stall_cycles++;
            if (axi4_awvalid || axi4_wvalid || axi4_arvalid) valid_seen = 1;
            if (b_hs) b_pend = 0;
            if (aw_hs) begin
                aw_log.push_back(axi4_awaddr);
                wptr = axi4_awaddr; w_in_burst = 0;
                last_awlen = axi4_awlen; last_awburst = axi4_awburst;
            end
            if (w_hs) begin
                mem[wptr[9:2]] = axi4_wdata;
                if (!first_w_seen) begin first_wdata = axi4_wdata; first_w_seen = 1; end
                if (axi4_wlast != (w_in_burst == 3)) wlast_viol++;
                last_wstrb = axi4_wstrb;
                wptr = wptr + 32'd4; w_in_burst++; w_beats++;
                if (axi4_wlast) b_pend = 1;
            end
            if (ar_hs) begin
                ar_log.push_back(axi4_araddr);
                rptr = axi4_araddr; r_left = 4;
                last_arlen = axi4_arlen; last_arburst = axi4_arburst;
            end
            if (r_hs) begin rptr = rptr + 32'd4; r_left--; end
        end
    end

    // Slave responder: drives ready/valid on the inactive edge.
    initial begin
        axi4_awready = 0; axi4_wready = 0; axi4_bvalid = 0; axi4_bresp = 0;
        axi4_arready = 0; axi4_rvalid = 0; axi4_rdata = 0; axi4_rresp = 0; axi4_rlast = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi4_awready = 0; axi4_wready = 0; axi4_bvalid = 0; axi4_arready = 0;
                axi4_rvalid = 0; axi4_rlast = 0; axi4_rdata = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (aw_hs) aw_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
                if (w_hs)  w_wait  = stall_en ? int'($urandom_range(0, 5)) : 0;
                if (ar_hs) ar_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
                if (r_hs)  r_wait  = stall_en ? int'($urandom_range(0, 5)) : 0;
                axi4_awready = axi4_awvalid && (aw_wait == 0);
                if (axi4_awvalid && aw_wait != 0) aw_wait--;
                axi4_wready = axi4_wvalid && (w_wait == 0);
                if (axi4_wvalid && w_wait != 0) w_wait--;
                axi4_arready = axi4_arvalid && (ar_wait == 0);
                if (axi4_arvalid && ar_wait != 0) ar_wait--;
                axi4_bvalid = b_pend;
                axi4_bresp  = 2'b00;
                if (r_left > 0 && r_wait == 0) begin
                    axi4_rvalid = 1;
                    axi4_rdata  = mem[rptr[9:2]] ^ {31'd0, rptr == flip_addr};
                    axi4_rlast  = (r_left == 1);
                    axi4_rresp  = 2'b00;
                end else begin
                    axi4_rvalid = 0;
                    axi4_rlast  = 0;
                    if (r_left > 0 && r_wait != 0) r_wait--;
                end
            end
        end
    end

    task automatic start_test(input logic [31:0] b, input logic [15:0] n);
        aw_log.delete(); ar_log.delete();
        first_w_seen = 0; valid_seen = 0; w_beats = 0; wlast_viol = 0;
        stall_viol = 0; stall_cycles = 0;
        @(negedge clk);
        base_addr = b; num_bursts = n; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; start = 0; base_addr = 0; num_bursts = 0; stall_en = 0; flip_addr = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done/pass", {done, pass}, 0);
        check("reset valids", {axi4_awvalid, axi4_wvalid, axi4_bready, axi4_arvalid, axi4_rready}, 0);
        check("reset err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Ideal slave, two bursts from 0x100.
        start_test(32'h100, 16'd2);
        check("A busy after start", busy, 1);
        wait_done("A");
        check("A aw count", aw_log.size(), 2);
        check("A aw0", aw_log[0], 32'h100);
        check("A aw1", aw_log[1], 32'h110);
        check("A ar0", ar_log[0], 32'h100);
        check("A ar1", ar_log[1], 32'h110);
        check("A wdata beat0", first_wdata, 32'hA5A5A4A5);
        check("A w beats", w_beats, 8);
        check("A wlast placement", wlast_viol, 0);
        check("A awlen/arlen", {last_awlen, last_arlen}, {8'd3, 8'd3});
        check("A awburst/arburst", {last_awburst, last_arburst}, 4'b0101);
        check("A wstrb", last_wstrb, 4'hF);
        check("A err_count", err_count, 0);
        check("A pass", pass, 1);
        check("A busy at end", busy, 0);
        repeat (5) @(negedge clk);
        check("A done held", done, 1);

        // One corrupted read beat at 0x108.
        flip_addr = 32'h108;
        start_test(32'h100, 16'd2);
        wait_done("B");
        check("B err_count", err_count, 1);
        check("B first_err_addr", first_err_addr, 32'h108);
        check("B pass", pass, 0);
        flip_addr = 32'h1;

        // Zero bursts: straight to done without bus traffic.
        start_test(32'h100, 16'd0);
        @(negedge clk);
        check("C done within 2", done, 1);
        check("C pass", pass, 1);
        check("C err cleared", err_count, 0);
        check("C first_err cleared", first_err_addr, 0);
        check("C no valid", valid_seen, 0);

        // Random stalls, unaligned base, and an ignored start while busy.
        stall_en = 1;
        start_test(32'h203, 16'd3);
        repeat (3) @(negedge clk);
        base_addr = 32'h500; num_bursts = 16'd1; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("D");
        check("D aw count", aw_log.size(), 3);
        check("D aw0 aligned", aw_log[0], 32'h200);
        check("D aw2", aw_log[2], 32'h220);
        check("D ar count", ar_log.size(), 3);
        check("D held while stalled", stall_viol, 0);
        check("D stalls occurred", stall_cycles != 0, 1);
        check("D pass", pass, 1);
        stall_en = 0;

        // Address wrap-around past 2^32.
        start_test(32'hFFFF_FFF8, 16'd2);
        wait_done("E");
        check("E aw0", aw_log[0], 32'hFFFF_FFF8);
        check("E aw1 wrapped", aw_log[1], 32'h0000_0008);
        check("E ar1 wrapped", ar_log[1], 32'h0000_0008);
        check("E pass", pass, 1);

        // Reset during write beat 2, then a clean rerun.
        start_test(32'h300, 16'd2);
        for (int n = 0; n < 100 && w_beats < 2; n++) @(negedge clk);
        check("F at beat 2", w_beats, 2);
        check("F wvalid before reset", axi4_wvalid, 1);
        rst_n = 0;
        #1;
        check("F flags zero", {busy, done, pass, axi4_awvalid, axi4_wvalid, axi4_bready,
                               axi4_arvalid, axi4_rready, axi4_wlast}, 0);
        check("F awaddr zero", axi4_awaddr, 0);
        check("F araddr zero", axi4_araddr, 0);
        check("F wdata zero", axi4_wdata, 0);
        check("F len/burst/strb zero", {axi4_awlen, axi4_arlen, axi4_awburst, axi4_arburst,
                                        axi4_wstrb}, 0);
        check("F err regs zero", {err_count, first_err_addr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start_test(32'h300, 16'd2);
        wait_done("F rerun");
        check("F rerun aw count", aw_log.size(), 2);
        check("F rerun pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_axi_bist.md
DDR3_AXI_BIST -- requirements
Module: ddr3_axi_bist

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16: beats per AXI burst, legal range 1..256.
REQ-002 SHALL have port clk  in  1: single clock, shared with the DDR3 AXI slave.
REQ-003 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1: one-cycle start request; sampled only in IDLE.
REQ-005 SHALL have port base_addr  in  32: byte address of the first burst; bits[1:0] are ignored and treated as 0.
REQ-006 SHALL have port num_bursts  in  16: number of bursts to write and then read.
REQ-007 SHALL have port busy  out  1: high while a test runs.
REQ-008 SHALL have port done  out  1: test complete; held until the next accepted start.
REQ-009 SHALL have port pass  out  1: done and err_count == 0.
REQ-010 SHALL have port err_count  out  16: saturating error count.
REQ-011 SHALL have port first_err_addr  out  32: byte address of the first failing beat.
REQ-012 SHALL have AXI4 master write-address ports: axi4_awaddr out 32, axi4_awlen out 8, axi4_awburst out 2, axi4_awvalid out 1, axi4_awready in 1.
REQ-013 SHALL have AXI4 master write-data ports: axi4_wdata out 32, axi4_wstrb out 4, axi4_wlast out 1, axi4_wvalid out 1, axi4_wready in 1.
REQ-014 SHALL have AXI4 master write-response ports: axi4_bresp in 2, axi4_bvalid in 1, axi4_bready out 1.
REQ-015 SHALL have AXI4 master read-address ports: axi4_araddr out 32, axi4_arlen out 8, axi4_arburst out 2, axi4_arvalid out 1, axi4_arready in 1.
REQ-016 SHALL have AXI4 master read-data ports: axi4_rdata in 32, axi4_rresp in 2, axi4_rlast in 1, axi4_rvalid in 1, axi4_rready out 1.
REQ-017 SHALL have no ID ports; the integrator ties awid and arid to 0.

Function
REQ-018 SHALL implement FSM states IDLE, WA, WD, WB, RA, RD, FIN.
- IDLE -> WA on start with num_bursts != 0.
- IDLE -> FIN on start with num_bursts == 0; no AXI traffic is issued.
REQ-019 SHALL, on an accepted start, clear err_count, first_err_addr and done, and set busy in the next cycle.
REQ-020 SHALL compute the burst k address as base_addr + k*BURST_LEN*4, modulo 2^32; wrap-around SHALL be allowed.
REQ-021 SHALL drive awlen = arlen = BURST_LEN-1, awburst = arburst = 2'b01 (INCR), and wstrb = 4'hF.
REQ-022 SHALL keep exactly one transaction outstanding at a time; address and data SHALL never overlap.
REQ-023 SHALL sequence the write phase as follows:
- WA: assert awvalid; hold addr and len stable until awready.
- WD: entered on the cycle after the AW handshake. wvalid is high every cycle, and the beat counter advances on wready. wlast is high on beat BURST_LEN-1.
- WB: bready is high; a B handshake with bresp != 0 counts one error.
- After WB, return to WA for the next burst, or go to RA after the last burst.
REQ-024 SHALL write data equal to the beat byte address XOR 32'hA5A5A5A5.
REQ-025 SHALL sequence the read phase as follows:
- RA: assert arvalid; hold stable until arready.
- RD: rready is high. Each beat SHALL be compared with the expected pattern.
- A data mismatch, rresp != 0, or rlast asserted on the wrong beat each count one error per beat.
- rlast missing on beat BURST_LEN-1 counts one error, and the burst SHALL still end there.
REQ-026 SHALL, on the first error, capture the beat address into first_err_addr.
REQ-027 SHALL saturate err_count at 16'hFFFF.
REQ-028 SHALL, in FIN, deassert busy, set done, and return to IDLE in the same cycle.
REQ-029 SHALL ignore start while busy.

Reset
REQ-030 SHALL force the following on rst_n low, immediately and asynchronously:
- FSM to IDLE.
- busy, done, pass, and all valid/ready outputs to 0.
- err_count and first_err_addr to 0.
- Address, len, data and wlast outputs to 0.
REQ-031 SHALL, on reset mid-burst, abandon the transaction; slave recovery is the system reset's responsibility.

Verification
REQ-032 SHALL cover: BURST_LEN=4, base 0x100, num_bursts=2, ideal slave -> AW at 0x100 and 0x110; wdata beat0 = 0xA5A5A4A5; done=1, pass=1, err_count=0.
REQ-033 SHALL cover: memory model flips bit 0 at 0x108 -> err_count=1, first_err_addr=0x108, pass=0.
REQ-034 SHALL cover: num_bursts=0 -> no valid asserted; done within 2 cycles of start; pass=1.
REQ-035 SHALL cover: random awready/wready/arready/rvalid stalls of 0-5 cycles -> outputs held stable while stalled; pass=1.
REQ-036 SHALL cover: base 0xFFFFFFF8, BURST_LEN=4, num_bursts=2 -> second burst address 0x00000008.
REQ-037 SHALL cover: rst_n low during WD beat 2 -> all outputs 0 at once; a new start then yields pass=1.
